// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle between an operand source and serial_adder.
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_full_adder.sv
// Single-bit combinational full adder cell.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);
    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (A & Cin) | (B & Cin);
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder cell plus a carry flop, LSB first,
// WIDTH+1 cycles per result with a start/busy/done handshake.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_e           state_r, state_nx_s;
    logic [WIDTH-1:0] a_sh_r, a_sh_nx_s;
    logic [WIDTH-1:0] b_sh_r, b_sh_nx_s;
    logic [WIDTH-1:0] acc_r, acc_nx_s;
    logic [WIDTH-1:0] sum_r, sum_nx_s;
    logic             carry_r, carry_nx_s;
    logic             cout_r, cout_nx_s;
    logic [CW-1:0]    cnt_r, cnt_nx_s;
    logic             busy_r, done_r;
    logic             fa_sum_s, fa_cout_s;

    full_adder u_fa (
        .A    (a_sh_r[0]),
        .B    (b_sh_r[0]),
        .Cin  (carry_r),
        .Sum  (fa_sum_s),
        .Cout (fa_cout_s)
    );

    // Next-state and next datapath values; sum/cout only move on the completing edge
    always_comb begin
        state_nx_s = state_r;
        a_sh_nx_s  = a_sh_r;
        b_sh_nx_s  = b_sh_r;
        acc_nx_s   = acc_r;
        carry_nx_s = carry_r;
        cnt_nx_s   = cnt_r;
        sum_nx_s   = sum_r;
        cout_nx_s  = cout_r;
        case (state_r)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nx_s = RUN;
                    a_sh_nx_s  = bus.a;
                    b_sh_nx_s  = bus.b;
                    carry_nx_s = bus.cin;
                    acc_nx_s   = {WIDTH{1'b0}};
                    cnt_nx_s   = {CW{1'b0}};
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                a_sh_nx_s  = {1'b0, a_sh_r[WIDTH-1:1]};
                b_sh_nx_s  = {1'b0, b_sh_r[WIDTH-1:1]};
                acc_nx_s   = WIDTH'({fa_sum_s, acc_r} >> 1'b1);
                carry_nx_s = fa_cout_s;
                cnt_nx_s   = cnt_r + CNT_ONE;
                if (cnt_r == CNT_LAST) begin
                    sum_nx_s   = acc_nx_s;
                    cout_nx_s  = fa_cout_s;
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Datapath registers; busy/done are registered from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh_r  <= {WIDTH{1'b0}};
            b_sh_r  <= {WIDTH{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            a_sh_r  <= a_sh_nx_s;
            b_sh_r  <= b_sh_nx_s;
            acc_r   <= acc_nx_s;
            sum_r   <= sum_nx_s;
            carry_r <= carry_nx_s;
            cout_r  <= cout_nx_s;
            cnt_r   <= cnt_nx_s;
            busy_r  <= (state_nx_s == RUN);
            done_r  <= (state_nx_s == DONE);
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: results modelled as plain a+b+cin.
module tb_serial_adder;
    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         done_prev = -1;
    int         done_last = -1;
    logic [W:0] exp_q[$];
    logic [W:0] mon_e;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_prev = done_last;
            done_last = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                checks--;
                chk("result", {23'd0, bus.cout, bus.sum}, {23'd0, mon_e});
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        bus.start = 1'b1;
        exp_q.push_back(model(a, b, cin));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (bus.done !== 1'b1 && n < 4 * W) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL %s: got no done within %0d cycles expected done pulse", name, 4 * W);
        end
        @(negedge clk);
    endtask

    initial begin
        int base;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_sum",  bus.sum,  0);
        chk("reset_cout", bus.cout, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic run with exact busy/done timing
        issue(8'h3C, 8'h0F, 1'b0);
        for (int i = 0; i < W; i++) begin
            chk("busy_in_run", bus.busy, 1);
            chk("done_in_run", bus.done, 0);
            @(negedge clk);
        end
        chk("done_pulse", bus.done, 1);
        chk("busy_at_done", bus.busy, 0);
        chk("t1_sum", bus.sum, 32'h4B);
        @(negedge clk);
        chk("done_one_cycle", bus.done, 0);

        issue(8'hFF, 8'h01, 1'b0);
        wait_done("t2a");
        chk("t2a_res", {bus.cout, bus.sum}, 32'h100);
        issue(8'hA5, 8'h5A, 1'b1);
        wait_done("t2b");
        chk("t2b_res", {bus.cout, bus.sum}, 32'h100);

        // Result held while idle
        issue(8'h00, 8'h00, 1'b1);
        wait_done("t3");
        repeat (5) begin
            chk("hold_done", bus.done, 0);
            chk("hold_res", {bus.cout, bus.sum}, 32'h001);
            @(negedge clk);
        end

        repeat (20) begin
            issue(W'($urandom), W'($urandom), 1'($urandom));
            wait_done("random");
        end

        // start and operand changes while busy are ignored
        base = done_cnt;
        issue(8'h10, 8'h20, 1'b0);
        for (int i = 0; i < W - 1; i++) begin
            bus.start = 1'($urandom);
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            bus.cin   = 1'($urandom);
            @(negedge clk);
        end
        bus.start = 1'b0;
        wait_done("inj1");
        repeat (3) @(negedge clk);
        chk("inj1_done_count", done_cnt - base, 1);
        chk("inj1_sum", bus.sum, 32'h30);

        // start held through the done cycle -> immediate back-to-back run
        issue(8'h55, 8'h66, 1'b0);
        repeat (W - 1) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h01;
        bus.b     = 8'h02;
        bus.cin   = 1'b0;
        exp_q.push_back(model(8'h01, 8'h02, 1'b0));
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        wait_done("inj2");
        chk("b2b_gap", done_last - done_prev, W + 1);
        chk("b2b_sum", {bus.cout, bus.sum}, 32'h003);

        // Reset in the middle of a run aborts it
        issue(8'hF0, 8'h0F, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_sum",  bus.sum,  0);
        chk("rst_cout", bus.cout, 0);
        rst_n = 1'b1;
        repeat (W + 2) @(negedge clk);
        chk("rst_no_done", bus.sum, 0);
        issue(8'h7E, 8'h81, 1'b1);
        wait_done("after_reset");
        chk("after_reset_res", {bus.cout, bus.sum}, 32'h100);

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial multi-bit adder built around the existing single-bit full_adder cell.
- Latches two WIDTH-bit operands and a carry-in, then adds one bit per clock, LSB first, through one full_adder instance and a carry flop.
- Delivers the WIDTH-bit sum and carry-out with a start/busy/done handshake.
- Sits downstream of operand sources and is the sequential consumer of full_adder; trades latency for area versus a ripple-carry array.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range is 2 or more.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- a  in  WIDTH  operand A; captured on the accepting edge.
- b  in  WIDTH  operand B; captured on the accepting edge.
- cin  in  1  carry-in; captured on the accepting edge.
- busy  out  1  high while bits are being processed (RUN).
- done  out  1  one-cycle pulse; sum/cout valid from this cycle.
- sum  out  WIDTH  result; held until the next completion.
- cout  out  1  final carry; held until the next completion.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n). No asynchronous reset terms.
- Reset values: state=IDLE; busy=0; done=0; sum=0; cout=0; internal shift registers, carry flop and counter=0.
- States:
  - IDLE: busy=0, done=0. If start=1, go to RUN and load:
    - a_sh<=a, b_sh<=b, carry<=cin, acc<=0, cnt<=0.
  - RUN: busy=1. Each edge:
    - full_adder inputs: A=a_sh[0], B=b_sh[0], Cin=carry.
    - acc<={Sum, acc[WIDTH-1:1]}.
    - carry<=Cout.
    - a_sh and b_sh shift right by one with zero fill.
    - cnt<=cnt+1.
    - When cnt==WIDTH-1 on an edge, that edge also does:
      - sum<={Sum, acc[WIDTH-1:1]}.
      - cout<=Cout.
      - state goes to DONE.
  - DONE: busy=0, done=1 for exactly one cycle.
    - start=1: reload as in IDLE and go to RUN (back-to-back). The done pulse is still exactly one cycle.
    - Otherwise go to IDLE.
- Latency:
  - start sampled at edge 0.
  - Bits processed at edges 1..WIDTH.
  - done high in the cycle after edge WIDTH.
  - One result per WIDTH+1 cycles; back-to-back throughput is also WIDTH+1 cycles.
- busy: high in the WIDTH cycles after the accepting edge.
- Ignored inputs:
  - start is ignored while in RUN.
  - a, b and cin changes after capture do not affect the result.
- Held outputs: sum and cout change only on the completing edge. They are never partial, and are held through IDLE indefinitely.
- Arithmetic: result equals {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), exact for all inputs.
- Counter width: $clog2(WIDTH); it never wraps during normal operation.
- Reset mid-operation: rst_n=0 at any edge returns everything to reset values. No done pulse is produced for the aborted operation.
- Simultaneous events: rst_n=0 together with start=1 means reset wins.

Decomposition:
- Package serial_adder_pkg:
  - state enum {IDLE, RUN, DONE} with 2-bit encoding.
  - Default WIDTH constant.
- Sub-module: one instance of the existing full_adder (ports A, B, Cin, Sum, Cout), purely combinational.
- Carry flop, shift registers, counter and FSM live in serial_adder.

Test Plan (WIDTH=8):
- a=8'h3C, b=8'h0F, cin=0, start pulse -> busy high 8 cycles; done 8 cycles after accept edge; sum=8'h4B, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1.
- a=8'h00, b=8'h00, cin=1 -> sum=8'h01, cout=0. After done, hold idle 5 cycles -> sum/cout unchanged, done=0.
- Error injection, part 1: start accepted with a=8'h10, b=8'h20; then start pulses and a/b change while busy -> ignored; sum=8'h30, exactly one done pulse.
- Error injection, part 2: start held high through the done cycle with new a=8'h01, b=8'h02 -> second run starts immediately; done pulses 9 cycles apart; second sum=8'h03.
- Reset mid-operation: rst_n low at cycle 4 of RUN -> next cycle busy=0, done=0, sum=0, cout=0. New start after release -> correct result.
